serializer_10b: RTL and testbench
=================================

// Module: serializer_10b
// PURPOSE
//  Parallel-to-serial stage directly downstream of encoder_8b10b: accepts 10-bit code
//  groups over a valid/ready handshake and shifts them out one bit per clk.
//  - Double-buffered: a hold register plus a shift register.
//  - Inserts a comma/idle code group whenever no symbol is waiting, so the line never stalls.
//  - After reset, sends a fixed burst of idle symbols for receiver alignment before accepting data.
// PARAMETERS
//  MSB_FIRST   1              1: transmit sym bit 9 first; 0: bit 0 first
//  IDLE_SYM    10'b0011111010 idle/comma group (K28.5, RD-), abcdei_fghj order
//  ALIGN_SYMS  4              idle symbols sent after reset before link_up; 0 = start in RUN
//  CNT_W       16             width of idle_cnt
// PORTS
//  clk        in   1      bit clock; all state on rising edge
//  rst        in   1      asynchronous, active-high reset
//  sym_in     in   10     code group from encoder_8b10b
//  sym_valid  in   1      sym_in valid
//  sym_ready  out  1      hold register empty and state==RUN; transfer = sym_valid & sym_ready
//  ser_out    out  1      registered serial bit
//  sym_first  out  1      high while ser_out carries the first bit of a code group
//  link_up    out  1      high in RUN state
//  idle_cnt   out  CNT_W  saturating count of idle insertions made in RUN (underruns)
// BEHAVIOUR
//  Reset values: ser_out=0, sym_first=0, link_up=(ALIGN_SYMS==0), idle_cnt=0, sym_ready=0 unless ALIGN_SYMS==0.
//  Reset internal state: bit counter cnt=0, sh=IDLE_SYM, hold_valid=0, align_cnt=0.
//  Reset asserted mid-symbol aborts immediately; hold contents are discarded; ALIGN restarts.
//  Bit slot: each edge, ser_out <= sh[MSB_FIRST ? 9-cnt : cnt] and sym_first <= (cnt==0).
//   cnt counts 0..9 and wraps.
//  Reload, on the edge where cnt==9:
//   - cnt <= 0
//   - sh <= hold_valid ? hold : IDLE_SYM
//   - hold_valid cleared if hold was used
//   Bit 0 of the new group appears on ser_out one edge later.
//  Handshake:
//   - sym_ready is combinational from registers only: !hold_valid && state==RUN.
//   - On a transfer: hold <= sym_in, hold_valid <= 1.
//   - sym_valid may drop without a transfer; no check is made.
//   - Transfer on the same edge as a reload with hold empty: the new symbol goes to hold and
//     sh loads IDLE_SYM. There is no bypass path.
//   - Latency from transfer to its first bit on ser_out: 2..11 edges, depending on cnt.
//  FSM:
//   - ALIGN: sym_ready=0. align_cnt increments on each reload. On the reload where
//     align_cnt==ALIGN_SYMS-1, state <= RUN and link_up <= 1.
//   - RUN: stays until reset.
//  idle_cnt: +1 on each reload in RUN where hold is empty. Reloads in ALIGN are not counted.
//   Saturates at 2^CNT_W-1; no wrap.
//  Throughput: with sym_valid held high in RUN, symbols are back-to-back; no idles are inserted.
//  sym_in is not checked for code validity; any 10-bit value is sent verbatim.
// TESTING
//  T1 rst high 3 edges, then release, ALIGN_SYMS=4 -> outputs at reset values during rst;
//   edges 1..10 give ser_out 0,0,1,1,1,1,1,0,1,0; sym_first high only after edges 1,11,21,31.
//  T2 Hold sym_valid=1 from reset with sym_in=10'b1010101010 -> sym_ready/link_up rise after edge 40;
//   first transfer at edge 41; ser_out=1,0,1,0.. after edges 51..60; idle_cnt stays 0.
//  T3 In RUN, send 10'b1100000111 then 10'b0011111000 back-to-back -> 20 contiguous bits
//   1100000111_0011111000; no idle in between; idle_cnt unchanged.
//  T4 In RUN, sym_valid=0 for 5 symbol times -> five IDLE_SYM groups on ser_out; idle_cnt +5.
//   With CNT_W=2, idle_cnt holds at 3.
//  T5 Assert rst mid-symbol with hold full -> ser_out=0, sym_ready=0 immediately; after release,
//   the held symbol is never sent; a full 4-idle ALIGN burst precedes link_up.
//  T6 MSB_FIRST=0, ALIGN_SYMS=0, send 10'b0000000001 -> sym_ready=1 after reset; after the
//   first IDLE group, ser_out shows 1 followed by nine 0s.

Source files
------------

// File: rtl/serializer_10b.sv
// Double-buffered 10-bit parallel-to-serial stage with idle/comma insertion and a
// post-reset alignment burst of idle groups.
module serializer_10b #(
   parameter bit               MSB_FIRST  = 1'b1,
   parameter logic [9:0]       IDLE_SYM   = 10'b0011111010,
   parameter int unsigned      ALIGN_SYMS = 4,
   parameter int unsigned      CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [9:0]       sym_in,
   input  logic             sym_valid,
   output logic             sym_ready,
   output logic             ser_out,
   output logic             sym_first,
   output logic             link_up,
   output logic [CNT_W-1:0] idle_cnt
);

   localparam int unsigned        AlignW    = (ALIGN_SYMS > 2) ? $clog2(ALIGN_SYMS) : 1;
   localparam logic [AlignW-1:0]  AlignLast = (ALIGN_SYMS == 0) ? '0 : AlignW'(ALIGN_SYMS - 1);
   localparam logic [CNT_W-1:0]   IdleMax   = '1;

   typedef enum logic [0:0] {StAlign, StRun} state_e;

   localparam state_e StReset = (ALIGN_SYMS == 0) ? StRun : StAlign;

   state_e             state;
   state_e             state_nxt;
   logic [3:0]         cnt;
   logic [9:0]         sh;
   logic [9:0]         hold;
   logic               hold_valid;
   logic [AlignW-1:0]  align_cnt;
   logic               reload;
   logic               xfer;
   logic [3:0]         bit_idx;

   assign reload    = (cnt == 4'd9);
   assign sym_ready = !hold_valid && (state == StRun);
   assign xfer      = sym_valid && sym_ready;
   assign link_up   = (state == StRun);
   assign bit_idx   = MSB_FIRST ? (4'd9 - cnt) : cnt;

   always_comb begin
      state_nxt = state;
      case (state)
         StAlign: if (reload && (align_cnt == AlignLast)) state_nxt = StRun;
         StRun:   state_nxt = StRun;
         default: state_nxt = StReset;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= StReset;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt        <= 4'd0;
         sh         <= IDLE_SYM;
         hold       <= 10'd0;
         hold_valid <= 1'b0;
         align_cnt  <= '0;
         ser_out    <= 1'b0;
         sym_first  <= 1'b0;
         idle_cnt   <= '0;
      end else begin
         ser_out   <= sh[bit_idx];
         sym_first <= (cnt == 4'd0);

         // No bypass: a symbol accepted on a reload edge waits a full group in hold.
         if (reload) begin
            cnt <= 4'd0;
            sh  <= hold_valid ? hold : IDLE_SYM;
            if (hold_valid) hold_valid <= 1'b0;
         end else begin
            cnt <= cnt + 4'd1;
         end

         if (xfer) begin
            hold       <= sym_in;
            hold_valid <= 1'b1;
         end

         if (reload && (state == StAlign)) align_cnt <= align_cnt + AlignW'(1);

         // Underrun counter: only idles inserted after alignment count.
         if (reload && (state == StRun) && !hold_valid && (idle_cnt != IdleMax)) begin
            idle_cnt <= idle_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_serializer_10b.sv
// Scoreboard bench for serializer_10b: stimulus pushes expected code groups, monitors
// reassemble the serial stream and compare whole groups.
module tb_serializer_10b;

   localparam logic [9:0] IDLE = 10'b0011111010;

   logic        clk;
   logic        rst;
   logic [9:0]  a_in;
   logic        a_valid;
   logic        a_ready, a_ser, a_first, a_link;
   logic [15:0] a_idle;
   logic        b_ready, b_ser, b_first, b_link;
   logic [1:0]  b_idle;
   logic [9:0]  c_in;
   logic        c_valid;
   logic        c_ready, c_ser, c_first, c_link;
   logic [15:0] c_idle;

   int checks = 0;
   int errors = 0;
   int edge_n;

   logic [9:0] q_a[$];
   logic [9:0] q_c[$];

   serializer_10b dut_a (
      .clk(clk), .rst(rst), .sym_in(a_in), .sym_valid(a_valid), .sym_ready(a_ready),
      .ser_out(a_ser), .sym_first(a_first), .link_up(a_link), .idle_cnt(a_idle)
   );

   serializer_10b #(.CNT_W(2)) dut_b (
      .clk(clk), .rst(rst), .sym_in(a_in), .sym_valid(a_valid), .sym_ready(b_ready),
      .ser_out(b_ser), .sym_first(b_first), .link_up(b_link), .idle_cnt(b_idle)
   );

   serializer_10b #(.MSB_FIRST(1'b0), .ALIGN_SYMS(0)) dut_c (
      .clk(clk), .rst(rst), .sym_in(c_in), .sym_valid(c_valid), .sym_ready(c_ready),
      .ser_out(c_ser), .sym_first(c_first), .link_up(c_link), .idle_cnt(c_idle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk or posedge rst) begin
      if (rst) edge_n <= 0;
      else     edge_n <= edge_n + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic wait_edge(input int n);
      while (edge_n < n) @(negedge clk);
   endtask

   // Monitor A: MSB-first reassembly.
   int         a_n = 0;
   logic [9:0] a_word;
   always @(negedge clk) begin
      if (rst) begin
         a_n = 0;
      end else begin
         if (a_first) begin
            chk("a_group_start", a_n, 0);
            a_n = 0;
         end
         a_word = {a_word[8:0], a_ser};
         a_n++;
         if (a_n == 10) begin
            if (q_a.size() != 0) chk("a_group", {22'd0, a_word}, {22'd0, q_a.pop_front()});
            a_n = 0;
         end
      end
   end

   // Monitor C: LSB-first reassembly.
   int         c_n = 0;
   logic [9:0] c_word;
   always @(negedge clk) begin
      if (rst) begin
         c_n = 0;
      end else begin
         if (c_first) begin
            chk("c_group_start", c_n, 0);
            c_n = 0;
         end
         c_word[c_n] = c_ser;
         c_n++;
         if (c_n == 10) begin
            if (q_c.size() != 0) chk("c_group", {22'd0, c_word}, {22'd0, q_c.pop_front()});
            c_n = 0;
         end
      end
   end

   initial begin
      #20000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b0; a_in = '0; a_valid = 1'b0; c_in = '0; c_valid = 1'b0;
      #1 rst = 1'b1;
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
         chk("rst_a_ser", a_ser, 0);
         chk("rst_a_first", a_first, 0);
         chk("rst_a_link", a_link, 0);
         chk("rst_a_ready", a_ready, 0);
         chk("rst_a_idle", a_idle, 0);
         chk("rst_c_ready", c_ready, 1);
         chk("rst_c_link", c_link, 1);
      end

      // Five idles: four alignment groups plus the one loaded on the RUN-entry reload.
      repeat (5) q_a.push_back(IDLE);
      q_a.push_back(10'b1010101010);
      q_c.push_back(IDLE);
      q_c.push_back(10'b0000000001);
      a_in = 10'b1010101010; a_valid = 1'b1;
      c_in = 10'b0000000001; c_valid = 1'b1;
      #2 rst = 1'b0;

      wait_edge(1);
      c_valid = 1'b0;
      chk("a_first_e1", a_first, 1);
      wait_edge(2);
      chk("a_first_e2", a_first, 0);
      chk("c_ready_busy", c_ready, 0);
      wait_edge(11);
      chk("a_first_e11", a_first, 1);
      wait_edge(15);
      chk("c_idle_e15", c_idle, 0);
      wait_edge(21);
      chk("c_idle_e21", c_idle, 1);
      wait_edge(39);
      chk("a_link_e39", a_link, 0);
      chk("a_ready_e39", a_ready, 0);
      wait_edge(40);
      chk("a_link_e40", a_link, 1);
      chk("a_ready_e40", a_ready, 1);

      wait_edge(41);
      chk("a_ready_e41", a_ready, 0);
      a_in = 10'b1100000111;
      q_a.push_back(10'b1100000111);
      wait_edge(51);
      chk("a_ready_e51", a_ready, 0);
      chk("a_idle_e51", a_idle, 0);
      a_in = 10'b0011111000;
      q_a.push_back(10'b0011111000);
      wait_edge(61);
      a_valid = 1'b0;
      repeat (5) q_a.push_back(IDLE);
      wait_edge(75);
      chk("a_idle_e75", a_idle, 0);
      wait_edge(81);
      chk("a_idle_e81", a_idle, 1);
      wait_edge(91);
      chk("b_idle_e91", b_idle, 2);
      wait_edge(121);
      chk("a_idle_e121", a_idle, 5);
      chk("b_idle_e121", b_idle, 3);

      // Fill hold, then reset mid-symbol before it can be sent.
      wait_edge(131);
      a_in = 10'b1111100000; a_valid = 1'b1;
      wait_edge(132);
      chk("a_ready_e132", a_ready, 0);
      chk("a_idle_e132", a_idle, 6);
      a_valid = 1'b0;
      wait_edge(135);
      #2 rst = 1'b1;
      #1;
      chk("rst2_a_ser", a_ser, 0);
      chk("rst2_a_ready", a_ready, 0);
      chk("rst2_a_link", a_link, 0);
      chk("rst2_a_first", a_first, 0);
      chk("rst2_a_idle", a_idle, 0);
      @(negedge clk);
      @(negedge clk);
      repeat (5) q_a.push_back(IDLE);
      #2 rst = 1'b0;

      wait_edge(39);
      chk("rst2_link_e39", a_link, 0);
      wait_edge(40);
      chk("rst2_link_e40", a_link, 1);
      chk("rst2_ready_e40", a_ready, 1);
      wait_edge(45);
      chk("rst2_idle_e45", a_idle, 0);
      wait_edge(51);
      chk("rst2_idle_e51", a_idle, 1);
      wait_edge(52);
      chk("q_a_drained", q_a.size(), 0);
      chk("q_c_drained", q_c.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
